gain_ramp_driver: RTL and testbench

Parametrised, pipelined volume stage for the distortion chain: takes the clipped sample stream, applies a pot-controlled tapered gain and saturates the result symmetrically. Gain changes are ramped once per frame to remove zipper noise. Sits between the clipper and the peak filter and supports interleaved multi-channel streams with a valid/ready handshake on both sides.

---
 rtl/gain_pkg.sv | 45 ++++
 rtl/volume_taper.sv | 27 ++
 rtl/gain_ramp_driver.sv | 111 +++++++++++
 tb/tb_gain_ramp_driver.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gain_pkg.sv
// Shared constants, the 256-entry pot taper and the shift/saturate helper
// used by the gain ramp stage.
package gain_pkg;

    localparam int DATA_W_DEF    = 24;
    localparam int GAIN_W_DEF    = 8;
    localparam int FRAC_W_DEF    = 6;
    localparam int CHANNELS_DEF  = 2;
    localparam int RAMP_STEP_DEF = 1;

    // Dead zone up to 8, unity (64) at mid-travel, 202 at full travel.
    function automatic logic [255:0][7:0] build_taper();
        logic [255:0][7:0] t;
        for (int v = 0; v < 256; v++) begin
            if (v <= 8)
                t[v] = 8'd0;
            else if (v <= 127)
                t[v] = 8'(((v - 8) * 64) / 119);
            else
                t[v] = 8'(64 + ((v - 127) * 138) / 128);
        end
        return t;
    endfunction

    localparam logic [255:0][7:0] TAPER = build_taper();

    // Floor-shift the product, then clamp symmetrically so the most
    // negative code never appears on the output.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] product,
        input int                 data_w,
        input int                 frac_w
    );
        logic signed [63:0] shifted;
        logic signed [63:0] max_pos;
        shifted = product >>> frac_w;
        max_pos = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        if (shifted > max_pos)
            return max_pos;
        if (shifted < -max_pos)
            return -max_pos;
        return shifted;
    endfunction

endpackage

// File: rtl/volume_taper.sv
// Registers the pot and mute inputs and turns them into the target gain.
module volume_taper import gain_pkg::*; #(
    parameter int GAIN_W = GAIN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        volume,
    input  logic              mute,
    output logic [GAIN_W-1:0] target
);

    logic [7:0] volume_q;
    logic       mute_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            volume_q <= 8'd0;
            mute_q   <= 1'b0;
            target   <= '0;
        end else begin
            volume_q <= volume;
            mute_q   <= mute;
            target   <= mute_q ? '0 : GAIN_W'(TAPER[volume_q]);
        end
    end

endmodule

// File: rtl/gain_ramp_driver.sv
// Two-stage volume stage: multiply by a per-frame ramped gain, then
// floor-shift and saturate, with valid/ready flow control on both sides.
module gain_ramp_driver import gain_pkg::*; #(
    parameter  int DATA_W    = DATA_W_DEF,
    parameter  int GAIN_W    = GAIN_W_DEF,
    parameter  int FRAC_W    = FRAC_W_DEF,
    parameter  int CHANNELS  = CHANNELS_DEF,
    parameter  int RAMP_STEP = RAMP_STEP_DEF,
    localparam int CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        volume,
    input  logic              mute,
    input  logic [DATA_W-1:0] d_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] d_out,
    output logic [CHAN_W-1:0] out_chan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              gain_settled
);

    localparam int PROD_W = DATA_W + GAIN_W + 1;

    logic [GAIN_W-1:0]        target;
    logic [GAIN_W-1:0]        gain_cur;
    logic [CHAN_W-1:0]        chan_cnt;
    logic [CHAN_W-1:0]        s1_chan;
    logic                     s1_valid;
    logic signed [PROD_W-1:0] s1_prod;
    logic signed [PROD_W-1:0] din_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [63:0]       prod_ext;
    logic signed [63:0]       sat_val;
    logic                     out_en;
    logic                     s1_en;
    logic                     accept;
    logic                     last_chan;

    volume_taper #(.GAIN_W(GAIN_W)) u_taper (
        .clk    (clk),
        .rst_n  (rst_n),
        .volume (volume),
        .mute   (mute),
        .target (target)
    );

    // Stage 1 may still fill while stage 2 waits, so no output is ever lost.
    assign out_en    = ~out_valid | out_ready;
    assign s1_en     = out_en | ~s1_valid;
    assign in_ready  = s1_en;
    assign accept    = in_valid & in_ready;
    assign last_chan = (chan_cnt == CHAN_W'(CHANNELS - 1));

    assign din_ext  = PROD_W'(signed'(d_in));
    assign gain_ext = PROD_W'({1'b0, gain_cur});
    assign prod_ext = 64'(s1_prod);
    assign sat_val  = sat_shift(prod_ext, DATA_W, FRAC_W);

    // Gain moves only on the last sample of a frame, so every sample of a
    // frame sees the value that was current at its first sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain_cur     <= '0;
            chan_cnt     <= '0;
            gain_settled <= 1'b0;
        end else begin
            gain_settled <= (gain_cur == target);
            if (accept) begin
                chan_cnt <= last_chan ? '0 : chan_cnt + 1'b1;
                if (last_chan) begin
                    if (gain_cur < target)
                        gain_cur <= ((target - gain_cur) > GAIN_W'(RAMP_STEP))
                                    ? gain_cur + GAIN_W'(RAMP_STEP) : target;
                    else if (gain_cur > target)
                        gain_cur <= ((gain_cur - target) > GAIN_W'(RAMP_STEP))
                                    ? gain_cur - GAIN_W'(RAMP_STEP) : target;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_prod   <= '0;
            s1_chan   <= '0;
            out_valid <= 1'b0;
            d_out     <= '0;
            out_chan  <= '0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_prod <= din_ext * gain_ext;
                    s1_chan <= chan_cnt;
                end
            end
            if (out_en) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    d_out    <= sat_val[DATA_W-1:0];
                    out_chan <= s1_chan;
                end
            end
        end
    end

endmodule

// File: tb/tb_gain_ramp_driver.sv
// Scoreboard bench for gain_ramp_driver: directed stimulus pushes expected
// samples, an independent monitor pops and compares on each output transfer.
module tb_gain_ramp_driver;

    typedef struct packed {
        logic [23:0] data;
        logic        chan;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  volume = 8'd0;
    logic        mute = 1'b0;
    logic [23:0] d_in = 24'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] d_out;
    logic [0:0]  out_chan;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        gain_settled;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   model_gain = 0;
    int   model_target = 0;
    logic model_chan = 1'b0;

    gain_ramp_driver dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .volume       (volume),
        .mute         (mute),
        .d_in         (d_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .d_out        (d_out),
        .out_chan     (out_chan),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .gain_settled (gain_settled)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [23:0] modelOut(input logic [23:0] d, input int g);
        longint p;
        p = longint'(signed'(d)) * longint'(g);
        p = p >>> 6;
        if (p > 64'sd8388607)
            p = 64'sd8388607;
        if (p < -64'sd8388607)
            p = -64'sd8388607;
        return p[23:0];
    endfunction

    task automatic applyStimulus(input logic [23:0] data, input logic [23:0] exp_data);
        int waited;
        waited = 0;
        d_in = data;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL in_ready_timeout: in_ready stuck at 0 for %0d cycles", waited);
            in_valid = 1'b0;
            return;
        end
        sb.push_back('{data: exp_data, chan: model_chan});
        if (model_chan) begin
            if (model_gain < model_target)
                model_gain = model_gain + 1;
            else if (model_gain > model_target)
                model_gain = model_gain - 1;
        end
        model_chan = ~model_chan;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sendFrames(input logic [23:0] data, input int frames);
        for (int f = 0; f < frames; f++) begin
            for (int c = 0; c < 2; c++)
                applyStimulus(data, modelOut(data, model_gain));
        end
    endtask

    task automatic setVolume(input logic [7:0] v, input logic m, input int tgt);
        volume = v;
        mute = m;
        model_target = tgt;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        #1;
        checkOutput("drain_pending", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output must match the oldest pending entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output: got d_out %h chan %0d, expected none",
                         d_out, out_chan);
            end else begin
                e = sb.pop_front();
                checkOutput("d_out", 32'(d_out), 32'(e.data));
                checkOutput("out_chan", 32'(out_chan), 32'(e.chan));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #3;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_d_out", 32'(d_out), 32'd0);
        checkOutput("reset_out_chan", 32'(out_chan), 32'd0);
        checkOutput("reset_gain_settled", 32'(gain_settled), 32'd0);
        #20;
        rst_n = 1'b1;

        // Fade-in to unity gain at mid-travel.
        setVolume(8'd127, 1'b0, 64);
        sendFrames(24'h010000, 2);
        checkOutput("settled_mid_ramp", 32'(gain_settled), 32'd0);
        sendFrames(24'h010000, 62);
        applyStimulus(24'h010000, 24'h010000);
        applyStimulus(24'h010000, 24'h010000);
        waitDrain();
        checkOutput("settled_unity", 32'(gain_settled), 32'd1);

        // Mute ramps down to silence one step per frame.
        setVolume(8'd127, 1'b1, 0);
        sendFrames(24'h010000, 64);
        applyStimulus(24'h010000, 24'h000000);
        applyStimulus(24'h010000, 24'h000000);
        waitDrain();
        checkOutput("settled_mute", 32'(gain_settled), 32'd1);

        // Full travel, then saturation and floor vectors at gain 202.
        setVolume(8'd255, 1'b0, 202);
        sendFrames(24'h001000, 202);
        waitDrain();
        checkOutput("settled_max", 32'(gain_settled), 32'd1);
        applyStimulus(24'h7FFFFF, 24'h7FFFFF);
        applyStimulus(24'h800000, 24'h800001);
        applyStimulus(24'hFFFFFF, 24'hFFFFFC);
        applyStimulus(24'h000040, 24'h0000CA);
        waitDrain();

        // Backpressure: output stalled for five cycles while input stays valid.
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    applyStimulus(24'h000040, 24'h0000CA);
            end
            begin
                out_ready = 1'b0;
                repeat (5) @(negedge clk);
                checkOutput("in_ready_full", 32'(in_ready), 32'd0);
                checkOutput("out_valid_held", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDrain();

        // Out_Ready pulsing on an empty pipeline produces nothing.
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("idle_out_valid", 32'(out_valid), 32'd0);

        // Ramp to the dead zone, then reverse direction twice mid-ramp.
        setVolume(8'd5, 1'b0, 0);
        sendFrames(24'h400000, 202);
        waitDrain();
        checkOutput("settled_dead_zone", 32'(gain_settled), 32'd1);
        applyStimulus(24'h400000, 24'h000000);
        applyStimulus(24'h400000, 24'h000000);
        setVolume(8'd255, 1'b0, 202);
        sendFrames(24'h001000, 40);
        setVolume(8'd5, 1'b0, 0);
        sendFrames(24'h001000, 10);
        setVolume(8'd255, 1'b0, 202);
        sendFrames(24'h001000, 10);
        waitDrain();

        // Reset pulse mid-frame with a sample parked at the output.
        setVolume(8'd127, 1'b0, 64);
        out_ready = 1'b0;
        applyStimulus(24'h010000, modelOut(24'h010000, model_gain));
        repeat (2) @(posedge clk);
        #2;
        checkOutput("pre_reset_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_out_valid", 32'(out_valid), 32'd0);
        sb.delete();
        model_gain = 0;
        model_chan = 1'b0;
        #10;
        rst_n = 1'b1;
        out_ready = 1'b1;
        setVolume(8'd127, 1'b0, 64);
        applyStimulus(24'h010000, 24'h000000);
        applyStimulus(24'h010000, 24'h000000);
        applyStimulus(24'h010000, 24'h000400);
        applyStimulus(24'h010000, 24'h000400);
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
